obwb_seq: RTL and testbench

OBWB_SEQ -- requirements
Module: obwb_seq

---
 rtl/obwb_pkg.sv | 25 ++
 rtl/obwb_merge.sv | 23 ++
 rtl/obwb_seq.sv | 173 +++++++++++++++++
 tb/tb_obwb_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obwb_pkg.sv
// Shared types and constants for the object writeback sequencer.
// Holds the sequencer state enum, phrase field positions and the phrase-2 address offset.
package obwb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StWr0,
        StWr2,
        StDone
    } obwb_state_e;

    // Phrase 0 fields
    localparam int unsigned HeightLsb = 14;
    localparam int unsigned HeightMsb = 23;
    localparam int unsigned DataLsb   = 43;
    localparam int unsigned DataMsb   = 63;

    // Phrase 2 fields
    localparam int unsigned RemLsb = 16;
    localparam int unsigned RemMsb = 23;

    localparam int unsigned Ph2Offset = 2;

endpackage

// File: rtl/obwb_merge.sv
// Combinational field merge: patches the updated height/data into phrase 0 and the
// updated remainder into phrase 2, leaving all other bits of the original phrases intact.
module obwb_merge
    import obwb_pkg::*;
(
    input  logic [63:0] obld0_i,
    input  logic [63:0] obld2_i,
    input  logic [9:0]  newheight_i,
    input  logic [20:0] newdata_i,
    input  logic [7:0]  newrem_i,
    output logic [63:0] phrase0_o,
    output logic [63:0] phrase2_o
);

    always_comb begin
        phrase0_o                     = obld0_i;
        phrase0_o[HeightMsb:HeightLsb] = newheight_i;
        phrase0_o[DataMsb:DataLsb]     = newdata_i;
        phrase2_o                     = obld2_i;
        phrase2_o[RemMsb:RemLsb]       = newrem_i;
    end

endmodule

// File: rtl/obwb_seq.sv
// Object writeback sequencer: writes the updated phrase 0 (and phrase 2 for scaled objects
// when OBWB_REMWR_EN is defined) back to memory, with an acknowledge timeout.
module obwb_seq
    import obwb_pkg::*;
#(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned TMO_W  = 8
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              wbkstart,
    input  logic [ADDR_W-1:0] objaddr,
    input  logic              scaled,
    input  logic [63:0]       obld0,
    input  logic [63:0]       obld2,
    input  logic              wbkdone,
    input  logic [20:0]       newdata,
    input  logic [9:0]        newheight,
    input  logic [7:0]        newrem,
    input  logic              wr_ack,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              busy,
    output logic              seqdone,
    output logic              wr_err
);

    localparam logic [TMO_W-1:0] TmoMax = {TMO_W{1'b1}};

    obwb_state_e       state_q, state_d;
    logic [ADDR_W-1:0] objaddr_q, objaddr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [63:0]       wr_data_q, wr_data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wr_req_q, wr_req_d;
    logic              busy_q, busy_d;
    logic              wr_err_q, wr_err_d;
    logic [63:0]       ph0_mrg, ph2_mrg;

`ifdef OBWB_REMWR_EN
    logic              scaled_q, scaled_d;
    logic [63:0]       ph2_q, ph2_d;
`else
    logic              unused_ph2;
    assign unused_ph2 = ^{ph2_mrg, scaled};
`endif

    obwb_merge u_merge (
        .obld0_i     (obld0),
        .obld2_i     (obld2),
        .newheight_i (newheight),
        .newdata_i   (newdata),
        .newrem_i    (newrem),
        .phrase0_o   (ph0_mrg),
        .phrase2_o   (ph2_mrg)
    );

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q   <= StIdle;
            objaddr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            tmo_q     <= '0;
            wr_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_err_q  <= 1'b0;
`ifdef OBWB_REMWR_EN
            scaled_q  <= 1'b0;
            ph2_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            objaddr_q <= objaddr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            tmo_q     <= tmo_d;
            wr_req_q  <= wr_req_d;
            busy_q    <= busy_d;
            wr_err_q  <= wr_err_d;
`ifdef OBWB_REMWR_EN
            scaled_q  <= scaled_d;
            ph2_q     <= ph2_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        objaddr_d = objaddr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tmo_d     = tmo_q;
        wr_err_d  = wr_err_q;
`ifdef OBWB_REMWR_EN
        scaled_d  = scaled_q;
        ph2_d     = ph2_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (wbkstart) begin
                    state_d   = StWait;
                    objaddr_d = objaddr;
                    wr_err_d  = 1'b0;
`ifdef OBWB_REMWR_EN
                    scaled_d  = scaled;
`endif
                end
            end
            StWait: begin
                // Phrase 0 is merged from the live inputs so the write is presented next cycle
                if (wbkdone) begin
                    state_d   = StWr0;
                    wr_addr_d = objaddr_q;
                    wr_data_d = ph0_mrg;
                    tmo_d     = '0;
`ifdef OBWB_REMWR_EN
                    ph2_d     = ph2_mrg;
`endif
                end
            end
            StWr0: begin
                if (wr_ack) begin
`ifdef OBWB_REMWR_EN
                    if (scaled_q) begin
                        state_d   = StWr2;
                        wr_addr_d = objaddr_q + ADDR_W'(Ph2Offset);
                        wr_data_d = ph2_q;
                        tmo_d     = '0;
                    end else begin
                        state_d = StDone;
                    end
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef OBWB_REMWR_EN
            StWr2: begin
                if (wr_ack) begin
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Timeout is shared by both write states; an ack in the last cycle still wins
        if ((state_q == StWr0 || state_q == StWr2) && !wr_ack) begin
            if (tmo_q == TmoMax) begin
                state_d  = StDone;
                wr_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        wr_req_d = (state_d == StWr0) || (state_d == StWr2);
        busy_d   = (state_d != StIdle);
    end

    always_comb begin
        wr_req  = wr_req_q;
        wr_addr = wr_addr_q;
        wr_data = wr_data_q;
        busy    = busy_q;
        wr_err  = wr_err_q;
        seqdone = (state_q == StDone);
    end

endmodule

// File: tb/tb_obwb_seq.sv
// Scoreboard bench for obwb_seq: the driver pushes expected writes and completions, a
// monitor pops and compares them whenever the DUT accepts a write or pulses seqdone.
module tb_obwb_seq;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned TMO_W  = 8;
`ifdef OBWB_REMWR_EN
    localparam bit RemEn = 1'b1;
`else
    localparam bit RemEn = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [63:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              resetl;
    logic              wbkstart, scaled, wbkdone, wr_ack;
    logic [ADDR_W-1:0] objaddr;
    logic [63:0]       obld0, obld2;
    logic [20:0]       newdata;
    logic [9:0]        newheight;
    logic [7:0]        newrem;
    logic              wr_req, busy, seqdone, wr_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;

    int  n_cmp = 0;
    int  n_fail = 0;
    wr_t exp_wr[$];
    bit  exp_done[$];
    int  req_total = 0;
    int  ack_delay = 0;
    bit  no_ack = 1'b0;
    int  ack_k = 0;

    logic              prev_req = 1'b0, prev_ack = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [63:0]       prev_data;

    obwb_seq #(.ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
        .clk       (clk),
        .resetl    (resetl),
        .wbkstart  (wbkstart),
        .objaddr   (objaddr),
        .scaled    (scaled),
        .obld0     (obld0),
        .obld2     (obld2),
        .wbkdone   (wbkdone),
        .newdata   (newdata),
        .newheight (newheight),
        .newrem    (newrem),
        .wr_ack    (wr_ack),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .seqdone   (seqdone),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference merges written as mask arithmetic over the documented bit fields
    function automatic logic [63:0] ref_ph0(logic [63:0] o0, logic [9:0] nh, logic [20:0] nd);
        logic [63:0] keep;
        keep = ~(64'hFFFF_F800_0000_0000 | 64'h0000_0000_00FF_C000);
        return (o0 & keep) | (64'(nd) << 43) | (64'(nh) << 14);
    endfunction

    function automatic logic [63:0] ref_ph2(logic [63:0] o2, logic [7:0] nr);
        return (o2 & ~64'h0000_0000_00FF_0000) | (64'(nr) << 16);
    endfunction

    // Memory side: ack the current write after ack_delay cycles; random ack noise when idle
    always @(negedge clk) begin
        if (wr_req === 1'b1) begin
            wr_ack = !no_ack && (ack_k == ack_delay);
            ack_k  = wr_ack ? 0 : ack_k + 1;
        end else begin
            ack_k  = 0;
            wr_ack = 1'($urandom % 2);
        end
    end

    // Monitor: compares accepted writes and completions against the scoreboard
    always @(negedge clk) begin
        wr_t e;
        bit  de;
        #2;
        if (resetl !== 1'b1) begin
            prev_req = 1'b0;
        end else begin
            if (wr_req) begin
                req_total++;
                if (prev_req && !prev_ack) begin
                    check("addr_stable", 64'(wr_addr), 64'(prev_addr));
                    check("data_stable", wr_data, prev_data);
                end
                if (wr_ack) begin
                    check("write_expected", 64'(exp_wr.size() != 0), 64'd1);
                    if (exp_wr.size() != 0) begin
                        e = exp_wr.pop_front();
                        check("wr_addr", 64'(wr_addr), 64'(e.a));
                        check("wr_data", wr_data, e.d);
                    end
                end
            end
            if (seqdone) begin
                check("done_expected", 64'(exp_done.size() != 0), 64'd1);
                if (exp_done.size() != 0) begin
                    de = exp_done.pop_front();
                    check("done_err", 64'(wr_err), 64'(de));
                end
            end
            prev_req  = wr_req;
            prev_ack  = wr_ack;
            prev_addr = wr_addr;
            prev_data = wr_data;
        end
    end

    task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic scl,
                           input logic [63:0] o0, input logic [63:0] o2,
                           input logic [20:0] nd, input logic [9:0] nh, input logic [7:0] nr,
                           input int dly, input bit noack, input bit extra, input int gap);
        int          nwr;
        int          req0;
        bit          got;
        logic [ADDR_W-1:0] a2;
        ack_delay = dly;
        no_ack    = noack;
        nwr = (RemEn && scl) ? 2 : 1;
        a2  = ADDR_W'((int'(addr) + 2) % (1 << ADDR_W));
        if (!noack) begin
            exp_wr.push_back('{a: addr, d: ref_ph0(o0, nh, nd)});
            if (nwr == 2) exp_wr.push_back('{a: a2, d: ref_ph2(o2, nr)});
        end
        exp_done.push_back(noack);
        req0 = req_total;

        @(negedge clk);
        wbkstart = 1'b1;
        objaddr  = addr;
        scaled   = scl;
        @(negedge clk);
        wbkstart = 1'b0;
        objaddr  = ADDR_W'($urandom);
        scaled   = ~scl;
        #3;
        check("busy_after_start", 64'(busy), 64'd1);
        check("err_cleared", 64'(wr_err), 64'd0);
        if (extra) begin
            wbkstart = 1'b1;
            @(negedge clk);
            wbkstart = 1'b0;
        end
        repeat (gap) @(negedge clk);
        @(negedge clk);
        wbkdone   = 1'b1;
        obld0     = o0;
        obld2     = o2;
        newdata   = nd;
        newheight = nh;
        newrem    = nr;
        @(negedge clk);
        wbkdone   = 1'b0;
        obld0     = {$urandom, $urandom};
        obld2     = {$urandom, $urandom};
        newdata   = 21'($urandom);
        newheight = 10'($urandom);
        newrem    = 8'($urandom);

        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #3;
            if (seqdone) begin
                got = 1'b1;
                break;
            end
        end
        check("seqdone_seen", 64'(got), 64'd1);
        check("req_cycles", 64'(req_total - req0),
              noack ? 64'(1 << TMO_W) : 64'(nwr * (dly + 1)));
        @(negedge clk);
        #3;
        check("seqdone_one_cycle", 64'(seqdone), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("req_idle", 64'(wr_req), 64'd0);
        no_ack = 1'b0;
    endtask

    initial begin
        wbkstart  = 1'b0;
        scaled    = 1'b0;
        wbkdone   = 1'b0;
        objaddr   = '0;
        obld0     = '0;
        obld2     = '0;
        newdata   = '0;
        newheight = '0;
        newrem    = '0;
        resetl    = 1'b1;
        #1 resetl = 1'b0;
        #12;
        check("rst_wr_req", 64'(wr_req), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_seqdone", 64'(seqdone), 64'd0);
        check("rst_wr_err", 64'(wr_err), 64'd0);
        @(negedge clk);
        resetl = 1'b1;
        repeat (2) @(negedge clk);

        // Unscaled reference write, ack after three cycles
        run_txn(21'h1000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF,
                21'h0AAAA, 10'h155, 8'h00, 3, 1'b0, 1'b0, 1);
        // Scaled with address wrap
        run_txn(21'h1FFFFF, 1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                21'($urandom), 10'($urandom), 8'h5A, 1, 1'b0, 1'b0, 0);
        // Zero height is written like any other
        run_txn(21'h00ABC, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
                21'($urandom), 10'h000, 8'($urandom), 0, 1'b0, 1'b1, 2);

        // Timeout: wr_err sets and stays until the next start
        run_txn(21'h04000, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
                21'($urandom), 10'($urandom), 8'($urandom), 0, 1'b1, 1'b0, 0);
        repeat (3) @(negedge clk);
        #3;
        check("err_sticky", 64'(wr_err), 64'd1);

        // wbkdone while idle does nothing
        @(negedge clk);
        wbkdone = 1'b1;
        @(negedge clk);
        wbkdone = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("idle_wbkdone_busy", 64'(busy), 64'd0);
        check("idle_wbkdone_req", 64'(wr_req), 64'd0);

        for (int t = 0; t < 24; t++) begin
            run_txn(ADDR_W'($urandom), 1'($urandom % 2), {$urandom, $urandom},
                    {$urandom, $urandom}, 21'($urandom), 10'($urandom), 8'($urandom),
                    $urandom_range(0, 4), 1'b0, ($urandom % 4) == 0, $urandom_range(0, 3));
        end

        // Reset in WR0 abandons the write without completion
        no_ack = 1'b1;
        @(negedge clk);
        wbkstart = 1'b1;
        objaddr  = 21'h12345;
        @(negedge clk);
        wbkstart = 1'b0;
        @(negedge clk);
        wbkdone = 1'b1;
        @(negedge clk);
        wbkdone = 1'b0;
        for (int i = 0; i < 8 && wr_req !== 1'b1; i++) @(negedge clk);
        check("rst_test_in_wr0", 64'(wr_req), 64'd1);
        #1 resetl = 1'b0;
        #1;
        check("midrst_req", 64'(wr_req), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_seqdone", 64'(seqdone), 64'd0);
        repeat (2) @(negedge clk);
        resetl = 1'b1;
        no_ack = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_err", 64'(wr_err), 64'd0);

        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("done_queue_drained", 64'(exp_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
